// File: rtl/cpu_trace_capture.sv
// Execution-trace recorder for the multicycle CPU: qualified samples go into a
// circular buffer, capture freezes a fixed number of samples after a trigger, then drains oldest-first.
module cpu_trace_capture #(
   parameter int DEPTH   = 16,
   parameter int PC_W    = 32,
   parameter int STATE_W = 5,
   parameter int TS_W    = 16,
   parameter int POST    = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [STATE_W-1:0]              state,
   input  logic [PC_W-1:0]                 pc_out,
   input  logic                            pc_en,
   input  logic                            pc_jal,
   input  logic                            pc_branch,
   input  logic                            arm,
   input  logic                            abort,
   input  logic [1:0]                      mode,
   input  logic                            trig_en,
   input  logic [PC_W-1:0]                 trig_pc,
   input  logic                            force_trig,
   output logic                            rd_valid,
   input  logic                            rd_ready,
   output logic [TS_W+STATE_W+PC_W+2:0]    rd_data,
   output logic                            busy,
   output logic                            triggered,
   output logic                            done,
   output logic [$clog2(DEPTH):0]          count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = TS_W + STATE_W + PC_W + 3;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DRAIN} fsm_e;

   fsm_e               fsm_q, fsm_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [TS_W-1:0]    ts_q, ts_d;
   logic               trig_q, trig_d;
   logic               done_q, done_d;
   logic [1:0]         mode_q, mode_d;
   logic [STATE_W-1:0] prev_q, prev_d;
   logic [AW-1:0]      post_q, post_d;
   logic [DW-1:0]      mem_q [DEPTH];

   logic               qual_s;
   logic               hit_s;
   logic               we_s;
   logic               rd_valid_s;
   logic [AW-1:0]      rd_ptr_s;
   logic [DW-1:0]      sample_s;
   logic [CW-1:0]      count_inc_s;

   assign hit_s       = (trig_en && (pc_out == trig_pc)) || force_trig;
   assign sample_s    = {ts_q, state, pc_out, pc_en, pc_jal, pc_branch};
   assign count_inc_s = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
   // With count == DEPTH the low bits are zero, so the oldest entry is the one about to be overwritten.
   assign rd_ptr_s    = wr_ptr_q - count_q[AW-1:0];
   assign rd_valid_s  = (fsm_q == S_DRAIN) && (count_q != CW'(0));

   // Sample qualifier selected by the mode latched at arm.
   always_comb begin
      qual_s = 1'b0;
      case (mode_q)
         2'd0:    qual_s = 1'b1;
         2'd1:    qual_s = (state != prev_q);
         2'd2:    qual_s = pc_en;
         2'd3:    qual_s = pc_jal | pc_branch;
         default: qual_s = 1'b0;
      endcase
   end

   // Capture FSM next-state and datapath updates.
   always_comb begin
      fsm_d    = fsm_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ts_d     = ts_q;
      trig_d   = trig_q;
      done_d   = done_q;
      mode_d   = mode_q;
      prev_d   = prev_q;
      post_d   = post_q;
      we_s     = 1'b0;
      if (abort) begin
         fsm_d   = S_IDLE;
         count_d = '0;
      end else begin
         case (fsm_q)
            S_IDLE: begin
               if (arm) begin
                  fsm_d    = S_ARMED;
                  wr_ptr_d = '0;
                  count_d  = '0;
                  ts_d     = '0;
                  trig_d   = 1'b0;
                  done_d   = 1'b0;
                  mode_d   = mode;
                  prev_d   = '1;
               end else begin
                  fsm_d = S_IDLE;
               end
            end
            S_ARMED: begin
               ts_d   = ts_q + TS_W'(1);
               prev_d = state;
               if (qual_s) begin
                  we_s     = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  count_d  = count_inc_s;
                  if (hit_s) begin
                     trig_d = 1'b1;
                     if (POST == 0) begin
                        fsm_d  = S_DRAIN;
                        done_d = 1'b1;
                     end else begin
                        fsm_d  = S_POST;
                        post_d = AW'(POST);
                     end
                  end else begin
                     fsm_d = S_ARMED;
                  end
               end else begin
                  fsm_d = S_ARMED;
               end
            end
            S_POST: begin
               ts_d   = ts_q + TS_W'(1);
               prev_d = state;
               if (qual_s) begin
                  we_s     = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  count_d  = count_inc_s;
                  post_d   = post_q - AW'(1);
                  if (post_q == AW'(1)) begin
                     fsm_d  = S_DRAIN;
                     done_d = 1'b1;
                  end else begin
                     fsm_d = S_POST;
                  end
               end else begin
                  fsm_d = S_POST;
               end
            end
            S_DRAIN: begin
               if (rd_valid_s && rd_ready) begin
                  count_d = count_q - CW'(1);
                  fsm_d   = (count_q == CW'(1)) ? S_IDLE : S_DRAIN;
               end else if (count_q == CW'(0)) begin
                  fsm_d = S_IDLE;
               end else begin
                  fsm_d = S_DRAIN;
               end
            end
            default: begin
               fsm_d   = S_IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   // Control and pointer state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q    <= S_IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ts_q     <= '0;
         trig_q   <= 1'b0;
         done_q   <= 1'b0;
         mode_q   <= 2'd0;
         prev_q   <= '0;
         post_q   <= '0;
      end else begin
         fsm_q    <= fsm_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ts_q     <= ts_d;
         trig_q   <= trig_d;
         done_q   <= done_d;
         mode_q   <= mode_d;
         prev_q   <= prev_d;
         post_q   <= post_d;
      end
   end

   // Trace buffer storage; contents are only observable through the gated read port.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_q[wr_ptr_q] <= sample_s;
      end
   end

   // Read port is combinational so one word can move every cycle.
   always_comb begin
      rd_data = '0;
      if (rd_valid_s) begin
         rd_data = mem_q[rd_ptr_s];
      end else begin
         rd_data = '0;
      end
   end

   assign rd_valid  = rd_valid_s;
   assign busy      = (fsm_q == S_ARMED) || (fsm_q == S_POST);
   assign triggered = trig_q;
   assign done      = done_q;
   assign count     = count_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Directed bench for cpu_trace_capture: three instances differing only in POST (3, 2, 0)
// share one stimulus set; each scenario checks the instance whose POST it needs.
module tb_cpu_trace_capture;

   localparam int DW = 56;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  state;
   logic [31:0] pc_out;
   logic        pc_en, pc_jal, pc_branch, arm, abort, trig_en, force_trig, rd_ready;
   logic [1:0]  mode;
   logic [31:0] trig_pc;

   logic          rd_valid_s  [3];
   logic [DW-1:0] rd_data_s   [3];
   logic          busy_s      [3];
   logic          triggered_s [3];
   logic          done_s      [3];
   logic [4:0]    count_s     [3];

   int errs   = 0;
   int checks = 0;
   logic [DW-1:0] exp_q [$];

   always #5 clk = ~clk;

   cpu_trace_capture #(.DEPTH(16), .PC_W(32), .STATE_W(5), .TS_W(16), .POST(3)) u_post3 (
      .clk(clk), .rst(rst), .state(state), .pc_out(pc_out), .pc_en(pc_en), .pc_jal(pc_jal),
      .pc_branch(pc_branch), .arm(arm), .abort(abort), .mode(mode), .trig_en(trig_en),
      .trig_pc(trig_pc), .force_trig(force_trig), .rd_valid(rd_valid_s[0]), .rd_ready(rd_ready),
      .rd_data(rd_data_s[0]), .busy(busy_s[0]), .triggered(triggered_s[0]), .done(done_s[0]),
      .count(count_s[0]));

   cpu_trace_capture #(.DEPTH(16), .PC_W(32), .STATE_W(5), .TS_W(16), .POST(2)) u_post2 (
      .clk(clk), .rst(rst), .state(state), .pc_out(pc_out), .pc_en(pc_en), .pc_jal(pc_jal),
      .pc_branch(pc_branch), .arm(arm), .abort(abort), .mode(mode), .trig_en(trig_en),
      .trig_pc(trig_pc), .force_trig(force_trig), .rd_valid(rd_valid_s[1]), .rd_ready(rd_ready),
      .rd_data(rd_data_s[1]), .busy(busy_s[1]), .triggered(triggered_s[1]), .done(done_s[1]),
      .count(count_s[1]));

   cpu_trace_capture #(.DEPTH(16), .PC_W(32), .STATE_W(5), .TS_W(16), .POST(0)) u_post0 (
      .clk(clk), .rst(rst), .state(state), .pc_out(pc_out), .pc_en(pc_en), .pc_jal(pc_jal),
      .pc_branch(pc_branch), .arm(arm), .abort(abort), .mode(mode), .trig_en(trig_en),
      .trig_pc(trig_pc), .force_trig(force_trig), .rd_valid(rd_valid_s[2]), .rd_ready(rd_ready),
      .rd_data(rd_data_s[2]), .busy(busy_s[2]), .triggered(triggered_s[2]), .done(done_s[2]),
      .count(count_s[2]));

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_word(input int ts, input int st, input logic [31:0] pc,
                                             input logic en, input logic jal, input logic br);
      logic [15:0] ts_v;
      logic [4:0]  st_v;
      ts_v = ts[15:0];
      st_v = st[4:0];
      return {ts_v, st_v, pc, en, jal, br};
   endfunction

   task automatic quiet_inputs();
      pc_en = 1'b0; pc_jal = 1'b0; pc_branch = 1'b0;
      arm = 1'b0; abort = 1'b0; force_trig = 1'b0; rd_ready = 1'b0;
   endtask

   task automatic do_abort();
      @(negedge clk);
      quiet_inputs();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic do_arm(input logic [1:0] m);
      @(negedge clk);
      quiet_inputs();
      mode = m;
      arm  = 1'b1;
   endtask

   // Drains instance d against exp_q; pat gives rd_ready for the first four cycles.
   task automatic drain(input int d, input logic [3:0] pat);
      int idx = 0;
      int cyc = 0;
      while (idx < exp_q.size() && cyc < 200) begin
         @(negedge clk);
         rd_ready = (cyc < 4) ? pat[cyc] : 1'b1;
         #1;
         if (rd_valid_s[d]) begin
            check_eq($sformatf("rd_data[%0d] inst%0d", idx, d), 64'(rd_data_s[d]), 64'(exp_q[idx]));
            if (rd_ready) idx++;
         end
         cyc++;
      end
      check_eq("drain_len", 64'(idx), 64'(exp_q.size()));
      @(negedge clk);
      rd_ready = 1'b0;
      #1;
      check_eq("after_drain_valid", 64'(rd_valid_s[d]), 64'd0);
      check_eq("after_drain_count", 64'(count_s[d]), 64'd0);
      check_eq("after_drain_data",  64'(rd_data_s[d]), 64'd0);
      check_eq("after_drain_done",  64'(done_s[d]), 64'd1);
      check_eq("after_drain_trig",  64'(triggered_s[d]), 64'd1);
   endtask

   initial begin
      int st_seq [6];
      logic [31:0] pc_v;
      st_seq = '{0, 0, 1, 1, 2, 2};
      rst = 1'b0;
      quiet_inputs();
      mode = 2'd0; state = 5'd0; pc_out = 32'd0; trig_en = 1'b0; trig_pc = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check_eq("reset_valid", 64'(rd_valid_s[d]), 64'd0);
         check_eq("reset_data",  64'(rd_data_s[d]),  64'd0);
         check_eq("reset_busy",  64'(busy_s[d]),     64'd0);
         check_eq("reset_trig",  64'(triggered_s[d]), 64'd0);
         check_eq("reset_done",  64'(done_s[d]),     64'd0);
         check_eq("reset_count", 64'(count_s[d]),    64'd0);
      end
      @(negedge clk);
      rst = 1'b1;

      // Mode 0, POST=3: 20 samples overflow the 16-entry buffer, trigger at pc 0x20.
      exp_q.delete();
      trig_en = 1'b1; trig_pc = 32'h20; state = 5'd3;
      do_arm(2'd0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         arm = 1'b0;
         pc_v = 32'hFFFF_FFE0 + 32'(4 * k);
         pc_out = pc_v;
         if (k >= 4) exp_q.push_back(mk_word(k, 3, pc_v, 1'b0, 1'b0, 1'b0));
         #1;
         if (k == 0) begin
            check_eq("m0_busy_start",  64'(busy_s[0]),  64'd1);
            check_eq("m0_count_start", 64'(count_s[0]), 64'd0);
         end
         if (k == 16) check_eq("m0_untrig_before", 64'(triggered_s[0]), 64'd0);
         if (k == 17) check_eq("m0_trig_after",    64'(triggered_s[0]), 64'd1);
      end
      @(negedge clk);
      #1;
      check_eq("m0_done",  64'(done_s[0]),     64'd1);
      check_eq("m0_valid", 64'(rd_valid_s[0]), 64'd1);
      check_eq("m0_count", 64'(count_s[0]),    64'd16);
      check_eq("m0_busy",  64'(busy_s[0]),     64'd0);
      drain(0, 4'b1001);

      // Mode 2, POST=2: trigger on the third pc_en (pc 0x114), five samples total.
      do_abort();
      exp_q.delete();
      trig_en = 1'b1; trig_pc = 32'h114;
      do_arm(2'd2);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         arm = 1'b0;
         pc_v = 32'h100 + 32'(4 * k);
         pc_out = pc_v;
         state = 5'(k);
         pc_en = k[0];
         pc_branch = (k == 3);
         pc_jal = (k == 4);
         if (k[0]) exp_q.push_back(mk_word(k, k, pc_v, 1'b1, 1'b0, k == 3));
      end
      @(negedge clk);
      quiet_inputs();
      #1;
      check_eq("m2_done",  64'(done_s[1]),      64'd1);
      check_eq("m2_valid", 64'(rd_valid_s[1]),  64'd1);
      check_eq("m2_count", 64'(count_s[1]),     64'd5);
      check_eq("m2_trig",  64'(triggered_s[1]), 64'd1);
      drain(1, 4'b1111);

      // POST=0 with force_trig on the first sample.
      do_abort();
      exp_q.delete();
      trig_en = 1'b0;
      do_arm(2'd0);
      @(negedge clk);
      arm = 1'b0; force_trig = 1'b1; pc_out = 32'h40; state = 5'd7;
      #1;
      check_eq("ft_busy",  64'(busy_s[2]),  64'd1);
      check_eq("ft_count", 64'(count_s[2]), 64'd0);
      @(negedge clk);
      force_trig = 1'b0;
      #1;
      check_eq("ft_done",  64'(done_s[2]),      64'd1);
      check_eq("ft_count1", 64'(count_s[2]),    64'd1);
      check_eq("ft_trig",  64'(triggered_s[2]), 64'd1);
      exp_q.push_back(mk_word(0, 7, 32'h40, 1'b0, 1'b0, 1'b0));
      drain(2, 4'b1111);

      // abort together with arm in IDLE.
      @(negedge clk);
      arm = 1'b1; abort = 1'b1;
      @(negedge clk);
      arm = 1'b0; abort = 1'b0;
      #1;
      check_eq("abarm_busy",  64'(busy_s[0]),     64'd0);
      check_eq("abarm_valid", 64'(rd_valid_s[0]), 64'd0);
      check_eq("abarm_count", 64'(count_s[0]),    64'd0);

      // abort mid-POST on the POST=3 instance.
      trig_en = 1'b1; trig_pc = 32'h8; state = 5'd1;
      do_arm(2'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         arm = 1'b0;
         pc_out = 32'(4 * k);
      end
      #1;
      check_eq("abpost_busy",  64'(busy_s[0]),      64'd1);
      check_eq("abpost_trig",  64'(triggered_s[0]), 64'd1);
      check_eq("abpost_count", 64'(count_s[0]),     64'd3);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      check_eq("abpost_busy_after",  64'(busy_s[0]),     64'd0);
      check_eq("abpost_valid_after", 64'(rd_valid_s[0]), 64'd0);
      check_eq("abpost_count_after", 64'(count_s[0]),    64'd0);

      // Mode 1 after the abort: only state changes are recorded.
      exp_q.delete();
      trig_en = 1'b0;
      do_arm(2'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         arm = 1'b0;
         pc_v = 32'h200 + 32'(4 * k);
         pc_out = pc_v;
         state = 5'(st_seq[k]);
         force_trig = (k == 4);
         if (k == 0 || k == 2 || k == 4) exp_q.push_back(mk_word(k, st_seq[k], pc_v, 1'b0, 1'b0, 1'b0));
         #1;
         if (k == 0) check_eq("m1_rearm_busy", 64'(busy_s[2]), 64'd1);
      end
      check_eq("m1_done",  64'(done_s[2]),  64'd1);
      check_eq("m1_count", 64'(count_s[2]), 64'd3);
      @(negedge clk);
      quiet_inputs();
      drain(2, 4'b1111);

      // Asynchronous reset in the middle of a capture.
      do_arm(2'd0);
      repeat (3) @(negedge clk);
      arm = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check_eq("rst_mid_busy",  64'(busy_s[0]),      64'd0);
      check_eq("rst_mid_count", 64'(count_s[0]),     64'd0);
      check_eq("rst_mid_trig",  64'(triggered_s[0]), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
